// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: line/state types and protocol constants shared by the USB receive and transmit paths
package usb_rx_pkg;
  typedef enum logic [2:0] {ST_ARM, ST_IDLE, ST_SYNC, ST_DATA, ST_EOP, ST_ERR_WAIT} rx_state_t;
  typedef enum logic [1:0] {LS_SE0, LS_K, LS_J, LS_SE1} line_state_t;
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;
  localparam logic [2:0] STUFF_LIMIT = 3'd6;
  function automatic line_state_t decode_line(input logic dp, input logic dm);
    return line_state_t'({dp, dm});
  endfunction
endpackage

// File: rtl/usb_rx_bit_timer.sv
// usb_rx_bit_timer: pad synchronizer, line-state decode and mid-bit sample strobe recovered from line transitions
module usb_rx_bit_timer import usb_rx_pkg::*; #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_plus_in,
  input  logic        d_minus_in,
  output line_state_t line_state,
  output logic        strobe
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [1:0] dp_s, dm_s;
  line_state_t ls_q;
  logic [CW-1:0] cnt;
  assign line_state = decode_line(dp_s[1], dm_s[1]);
  assign strobe = cnt == CW'(CLKS_PER_BIT / 2) && line_state == ls_q;
  // synchronizer resets to J so leaving reset on an idle bus is not seen as an edge
  always_ff @(posedge clk)
    if (rst) begin
      dp_s <= 2'b11;
      dm_s <= 2'b00;
      ls_q <= LS_J;
      cnt  <= '0;
    end else begin
      dp_s <= {dp_s[0], d_plus_in};
      dm_s <= {dm_s[0], d_minus_in};
      ls_q <= line_state;
      cnt  <= (line_state != ls_q || cnt == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: full-speed USB receiver with SYNC detect, NRZI decode, bit unstuffing, byte assembly and EOP check
module usb_rx_decoder import usb_rx_pkg::*; #(
  parameter int CLKS_PER_BIT = 8,
  parameter int IDLE_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus_in,
  input  logic       d_minus_in,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_packet_start,
  output logic       rx_packet_done,
  output logic       rx_error,
  output logic       rx_pid_err,
  output logic       receiving
);
  localparam int JW = $clog2(IDLE_BITS + 1);
  rx_state_t state, state_n;
  line_state_t ls, prev_ls;
  logic strobe, is_j, is_jk, dec, stuff_due, byte_end;
  logic start_p, done_p, err_p, shift_en, first_byte;
  logic [JW-1:0] jcnt;
  logic [2:0] bit_cnt, ones;
  logic [1:0] se0_cnt;
  logic [6:0] sr;
  logic [7:0] byte_n;

  usb_rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk), .rst(rst), .d_plus_in(d_plus_in), .d_minus_in(d_minus_in),
    .line_state(ls), .strobe(strobe)
  );

  assign is_j      = ls == LS_J;
  assign is_jk     = ls == LS_J || ls == LS_K;
  assign dec       = ls == prev_ls;
  assign stuff_due = ones == STUFF_LIMIT;
  assign byte_n    = {dec, sr};
  assign byte_end  = shift_en && bit_cnt == 3'd7;

  always_comb begin
    state_n  = state;
    start_p  = 1'b0;
    done_p   = 1'b0;
    err_p    = 1'b0;
    shift_en = 1'b0;
    if (strobe)
      case (state)
        ST_ARM:  if (is_j && jcnt >= JW'(IDLE_BITS - 1)) state_n = ST_IDLE;
        ST_IDLE: state_n = ls == LS_K ? ST_SYNC : ls == LS_SE1 ? ST_ARM : ST_IDLE;
        ST_SYNC:
          if (!is_jk || dec != SYNC_PATTERN[bit_cnt]) begin
            state_n = ST_ERR_WAIT;
            err_p   = 1'b1;
          end else if (bit_cnt == 3'd7) begin
            state_n = ST_DATA;
            start_p = 1'b1;
          end
        // after STUFF_LIMIT ones the next bit must be a 0 and is dropped
        ST_DATA:
          if (ls == LS_SE1 || (stuff_due && (ls == LS_SE0 || dec))) begin
            state_n = ST_ERR_WAIT;
            err_p   = 1'b1;
          end else if (ls == LS_SE0) state_n = ST_EOP;
          else shift_en = !stuff_due;
        ST_EOP:
          if (is_j && se0_cnt == 2'd2) begin
            state_n = ST_IDLE;
            done_p  = bit_cnt == 3'd0;
            err_p   = bit_cnt != 3'd0;
          end else if (ls != LS_SE0) begin
            state_n = ST_ERR_WAIT;
            err_p   = 1'b1;
          end
        ST_ERR_WAIT: if (is_j && (se0_cnt != 2'd0 || jcnt >= JW'(IDLE_BITS - 1))) state_n = ST_ARM;
        default: state_n = ST_ARM;
      endcase
  end

  always_ff @(posedge clk)
    if (rst) begin
      state           <= ST_ARM;
      prev_ls         <= LS_J;
      jcnt            <= '0;
      bit_cnt         <= '0;
      ones            <= '0;
      se0_cnt         <= '0;
      sr              <= '0;
      first_byte      <= 1'b0;
      rx_data         <= '0;
      rx_data_valid   <= 1'b0;
      rx_packet_start <= 1'b0;
      rx_packet_done  <= 1'b0;
      rx_error        <= 1'b0;
      rx_pid_err      <= 1'b0;
      receiving       <= 1'b0;
    end else begin
      state           <= state_n;
      rx_packet_start <= start_p;
      rx_packet_done  <= done_p;
      rx_error        <= err_p;
      rx_data_valid   <= byte_end;
      receiving       <= start_p ? 1'b1 : (done_p || err_p) ? 1'b0 : receiving;
      rx_pid_err      <= start_p ? 1'b0 : (byte_end && first_byte && byte_n[7:4] != ~byte_n[3:0]) ? 1'b1 : rx_pid_err;
      if (byte_end) rx_data <= byte_n;
      if (shift_en) sr <= byte_n[7:1];
      if (strobe) begin
        if (is_jk) prev_ls <= ls;
        jcnt       <= (state_n != state || !is_j) ? '0 : jcnt == JW'(IDLE_BITS) ? jcnt : jcnt + 1'b1;
        se0_cnt    <= state_n != state ? {1'b0, state_n == ST_EOP} :
                      ls == LS_SE0 ? (se0_cnt == 2'd2 ? se0_cnt : se0_cnt + 1'b1) : 2'd0;
        bit_cnt    <= (state == ST_IDLE && state_n == ST_SYNC) ? 3'd1 : start_p ? 3'd0 :
                      (state == ST_SYNC || shift_en) ? bit_cnt + 1'b1 : bit_cnt;
        ones       <= start_p ? 3'd1 : (state != ST_DATA || !is_jk) ? ones : (stuff_due || !dec) ? 3'd0 : ones + 1'b1;
        first_byte <= start_p ? 1'b1 : byte_end ? 1'b0 : first_byte;
      end
    end
endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb_usb_rx_decoder: drives NRZI/stuffed USB packets onto the pads and checks delivered bytes and status pulses
module tb_usb_rx_decoder;
  localparam int CPB = 8;
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;
  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0, rst = 1'b1, d_plus_in = 1'b1, d_minus_in = 1'b0;
  logic [7:0] rx_data;
  logic rx_data_valid, rx_packet_start, rx_packet_done, rx_error, rx_pid_err, receiving;

  int n_chk = 0, n_fail = 0;
  int e_cur = 0;
  bit jitter = 1'b0;
  int n_start = 0, n_done = 0, n_err = 0, n_both = 0, n_recv = 0;
  int b_start, b_done, b_err, b_recv, b_bytes;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  usb_rx_decoder #(.CLKS_PER_BIT(CPB), .IDLE_BITS(8)) dut (
    .clk(clk), .rst(rst), .d_plus_in(d_plus_in), .d_minus_in(d_minus_in),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_packet_start(rx_packet_start),
    .rx_packet_done(rx_packet_done), .rx_error(rx_error), .rx_pid_err(rx_pid_err), .receiving(receiving)
  );

  always @(negedge clk) begin
    if (rx_data_valid) got_q.push_back(rx_data);
    n_start += int'(rx_packet_start);
    n_done  += int'(rx_packet_done);
    n_err   += int'(rx_error);
    n_both  += int'(rx_packet_done && rx_error);
    n_recv  += int'(receiving);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_start = n_start;
    b_done  = n_done;
    b_err   = n_err;
    b_recv  = n_recv;
    b_bytes = got_q.size();
  endtask

  // each bit edge lands within +/-1 clock of its nominal position when jitter is on
  task automatic drive(input logic [1:0] lv);
    int e_nxt, n;
    e_nxt = jitter ? int'($urandom_range(2)) - 1 : 0;
    n = CPB + e_nxt - e_cur;
    e_cur = e_nxt;
    {d_plus_in, d_minus_in} = lv;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_packet(input byte_q_t pkt, input int extra, input bit flip, output int pre_bits);
    logic bits[$];
    logic b;
    logic [1:0] lv;
    int ones;
    bit flipped;
    pre_bits = -1;
    ones = 1;
    flipped = 1'b0;
    for (int i = 0; i < 7; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    for (int i = 0; i < pkt.size() * 8 + extra; i++) begin
      b = i < pkt.size() * 8 ? pkt[i / 8][i % 8] : 1'($urandom_range(1));
      bits.push_back(b);
      ones = b ? ones + 1 : 0;
      if (ones == 6) begin
        if (flip && !flipped) begin
          bits.push_back(1'b1);
          pre_bits = i + 1;
          flipped = 1'b1;
        end else bits.push_back(1'b0);
        ones = 0;
      end
    end
    repeat (12) drive(J);
    lv = J;
    foreach (bits[i]) begin
      if (!bits[i]) lv = (lv == J) ? K : J;
      drive(lv);
    end
    drive(SE0);
    drive(SE0);
    repeat (3) drive(J);
  endtask

  task automatic run_case(input string tag, input byte_q_t pkt, input int extra, input bit flip);
    int pre, n_exp, n_got;
    bit bad;
    logic pid_bad;
    snap();
    send_packet(pkt, extra, flip, pre);
    n_exp = flip ? pre / 8 : pkt.size();
    bad = flip || (extra % 8 != 0);
    pid_bad = n_exp > 0 && pkt[0][7:4] != ~pkt[0][3:0];
    n_got = got_q.size() - b_bytes;
    check({tag, ":start"}, n_start - b_start, 1);
    check({tag, ":done"}, n_done - b_done, bad ? 0 : 1);
    check({tag, ":err"}, n_err - b_err, bad ? 1 : 0);
    check({tag, ":nbytes"}, n_got, n_exp);
    for (int i = 0; i < n_exp && i < n_got; i++) check({tag, ":byte"}, int'(got_q[b_bytes + i]), int'(pkt[i]));
    check({tag, ":pid_err"}, int'(rx_pid_err), int'(pid_bad));
    check({tag, ":recv_seen"}, int'(n_recv > b_recv), 1);
    check({tag, ":recv_idle"}, int'(receiving), 0);
  endtask

  initial begin
    byte_q_t p;
    int pre;
    repeat (4) @(negedge clk);
    check("rst_data", int'(rx_data), 0);
    check("rst_valid", int'(rx_data_valid), 0);
    check("rst_start", int'(rx_packet_start), 0);
    check("rst_done", int'(rx_packet_done), 0);
    check("rst_err", int'(rx_error), 0);
    check("rst_pid", int'(rx_pid_err), 0);
    check("rst_recv", int'(receiving), 0);
    rst = 1'b0;
    @(negedge clk);
    run_case("pid_a5", '{8'hA5}, 0, 1'b0);
    run_case("stuffed", '{8'hC3, 8'hFF, 8'h3F}, 0, 1'b0);
    run_case("stuff_err", '{8'hC3, 8'hFF, 8'h3F}, 0, 1'b1);
    run_case("after_err", '{8'hA5, 8'h00}, 0, 1'b0);
    run_case("misalign", '{8'hE1}, 5, 1'b0);
    run_case("pid_5a", '{8'h5A, 8'h77}, 0, 1'b0);
    run_case("pid_bad", '{8'h5B, 8'h77}, 0, 1'b0);
    run_case("pid_clear", '{8'hD2}, 0, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      jitter = pass == 1;
      p = '{8'hC3, 8'h12, 8'h34};
      fork
        send_packet(p, 0, 1'b0, pre);
        begin
          repeat (24 * CPB) @(negedge clk);
          rst = 1'b1;
          repeat (3) @(negedge clk);
          rst = 1'b0;
          snap();
        end
      join
      check("frag_start", n_start - b_start, 0);
      check("frag_done", n_done - b_done, 0);
      check("frag_err", n_err - b_err, 0);
      check("frag_bytes", got_q.size() - b_bytes, 0);
      run_case("post_rst", '{8'h4B, 8'hFF, 8'hFF, 8'h81}, 0, 1'b0);
    end
    for (int t = 0; t < 16; t++) begin
      byte_q_t q;
      logic [7:0] v;
      int len;
      jitter = $urandom_range(1) == 1;
      len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) begin
        v = 8'($urandom);
        if (i == 0 && $urandom_range(1) == 1) v[3:0] = ~v[7:4];
        q.push_back(v);
      end
      run_case("random", q, $urandom_range(3) == 0 ? int'($urandom_range(1, 7)) : 0, 1'b0);
    end
    check("done_err_overlap", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
